// File: rtl/mannix_mem_pkg.sv
// mannix_mem_pkg: shared types, arbitration modes and line-width helpers for the memory read path
package mannix_mem_pkg;
  typedef enum logic {IDLE, BUSY} arb_state_t;
  localparam int ARB_RR = 0;
  localparam int ARB_FIXED = 1;
  function automatic int line_w(int word_width, int num_words);
    return word_width * num_words;
  endfunction
  function automatic int last_valid_w(int word_width, int num_words);
    return $clog2(word_width * num_words / 8);
  endfunction
endpackage

// File: rtl/mem_read_arb_rr_pick.sv
// rr_pick: combinational rotating-priority picker using double-width mask-and-find-first
module rr_pick #(
  parameter int N = 4,
  localparam int CH_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [CH_W-1:0] ptr,
  input  logic            mode,
  output logic            valid,
  output logic [CH_W-1:0] index
);
  logic [CH_W-1:0] start;
  logic [2*N-1:0] masked;
  always_comb begin
    start = mode ? CH_W'(0) : ptr;
    masked = {req, req} & ~(((2*N)'(1) << start) - (2*N)'(1));
    valid = |req;
    index = '0;
    for (int i = 2*N-1; i >= 0; i--) if (masked[i]) index = CH_W'(i < N ? i : i - N);
  end
endmodule

// File: rtl/mem_read_arb.sv
// mem_read_arb: locks one of NUM_CH client read channels onto the shared memory read port until its last beat
module mem_read_arb import mannix_mem_pkg::*; #(
  parameter int WORD_WIDTH = 8,
  parameter int NUM_WORDS_IN_LINE = 32,
  parameter int ADDR_WIDTH = 19,
  parameter int NUM_CH = 4,
  parameter int MODE = ARB_RR,
  localparam int LINE_W = line_w(WORD_WIDTH, NUM_WORDS_IN_LINE),
  localparam int LAST_VALID_W = last_valid_w(WORD_WIDTH, NUM_WORDS_IN_LINE),
  localparam int CH_W = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            cl_req,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] cl_start_addr,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] cl_size_bytes,
  output logic [NUM_CH-1:0]            cl_gnt,
  output logic [NUM_CH-1:0]            cl_last,
  output logic [LINE_W-1:0]            cl_data,
  output logic [LAST_VALID_W-1:0]      cl_last_valid,
  output logic                         mem_req,
  output logic [ADDR_WIDTH-1:0]        mem_start_addr,
  output logic [ADDR_WIDTH-1:0]        mem_size_bytes,
  input  logic                         mem_gnt,
  input  logic                         mem_last,
  input  logic [LINE_W-1:0]            mem_data,
  input  logic [LAST_VALID_W-1:0]      mem_last_valid,
  output logic                         busy,
  output logic [CH_W-1:0]              owner
);
  arb_state_t state, state_d;
  logic [CH_W-1:0] ptr, win;
  logic win_valid, done;
  assign done = mem_gnt & mem_last;
  rr_pick #(.N(NUM_CH)) u_pick (
    .req(cl_req),
    .ptr(ptr),
    .mode(MODE == ARB_FIXED),
    .valid(win_valid),
    .index(win)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      ptr <= '0;
      mem_start_addr <= '0;
      mem_size_bytes <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE && win_valid) begin
        owner <= win;
        mem_start_addr <= cl_start_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
        mem_size_bytes <= cl_size_bytes[win*ADDR_WIDTH +: ADDR_WIDTH];
      end
      if (state == BUSY && done && MODE == ARB_RR) ptr <= owner == CH_W'(NUM_CH-1) ? '0 : owner + 1'b1;
    end
  end
  always_comb state_d = state == IDLE ? (win_valid ? BUSY : IDLE) : (done ? IDLE : BUSY);
  // Return path is purely combinational so beats reach the owner with no added latency.
  always_comb begin
    busy = state == BUSY;
    mem_req = busy;
    cl_gnt = '0;
    cl_last = '0;
    cl_gnt[owner] = busy & mem_gnt;
    cl_last[owner] = busy & done;
    cl_data = mem_data;
    cl_last_valid = mem_last_valid;
  end
endmodule

// File: tb/tb_mem_read_arb.sv
// tb_mem_read_arb: directed scoreboard bench for round-robin and fixed-priority arbiter instances
module tb_mem_read_arb;
  import mannix_mem_pkg::*;
  localparam int N = 4, AW = 19, LW = 256, VW = 5;
  typedef struct {int ch; bit last; logic [VW-1:0] lv; logic [LW-1:0] data;} exp_t;
  logic clk = 0, rst = 1, sel = 0;
  always #5 clk = ~clk;
  logic [N-1:0] cl_req;
  logic [N*AW-1:0] cl_start_addr, cl_size_bytes;
  logic mem_gnt, mem_last;
  logic [LW-1:0] mem_data;
  logic [VW-1:0] mem_last_valid;
  logic [N-1:0] r_gnt, r_last, f_gnt, f_last, c_gnt, c_last;
  logic [LW-1:0] r_data, f_data, c_data;
  logic [VW-1:0] r_lv, f_lv, c_lv;
  logic r_req, f_req, c_req, r_busy, f_busy, c_busy;
  logic [AW-1:0] r_addr, f_addr, c_addr, r_size, f_size, c_size;
  logic [1:0] r_owner, f_owner, c_owner;
  int vectors = 0, miscompares = 0, nbeat = 0;
  exp_t sb[$];
  exp_t e;

  mem_read_arb #(.MODE(ARB_RR)) dut_rr (
    .clk(clk), .rst(rst), .cl_req(cl_req), .cl_start_addr(cl_start_addr), .cl_size_bytes(cl_size_bytes),
    .cl_gnt(r_gnt), .cl_last(r_last), .cl_data(r_data), .cl_last_valid(r_lv),
    .mem_req(r_req), .mem_start_addr(r_addr), .mem_size_bytes(r_size),
    .mem_gnt(mem_gnt), .mem_last(mem_last), .mem_data(mem_data), .mem_last_valid(mem_last_valid),
    .busy(r_busy), .owner(r_owner)
  );
  mem_read_arb #(.MODE(ARB_FIXED)) dut_fx (
    .clk(clk), .rst(rst), .cl_req(cl_req), .cl_start_addr(cl_start_addr), .cl_size_bytes(cl_size_bytes),
    .cl_gnt(f_gnt), .cl_last(f_last), .cl_data(f_data), .cl_last_valid(f_lv),
    .mem_req(f_req), .mem_start_addr(f_addr), .mem_size_bytes(f_size),
    .mem_gnt(mem_gnt), .mem_last(mem_last), .mem_data(mem_data), .mem_last_valid(mem_last_valid),
    .busy(f_busy), .owner(f_owner)
  );
  assign c_gnt = sel ? f_gnt : r_gnt;
  assign c_last = sel ? f_last : r_last;
  assign c_data = sel ? f_data : r_data;
  assign c_lv = sel ? f_lv : r_lv;
  assign c_req = sel ? f_req : r_req;
  assign c_busy = sel ? f_busy : r_busy;
  assign c_addr = sel ? f_addr : r_addr;
  assign c_size = sel ? f_size : r_size;
  assign c_owner = sel ? f_owner : r_owner;

  task automatic chk(string name, logic [LW-1:0] act, logic [LW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (c_gnt !== '0 || c_last !== '0) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_beat: cl_gnt=%b cl_last=%b expected no beat", c_gnt, c_last);
      end else begin
        e = sb.pop_front();
        chk("beat_gnt", c_gnt, 4'b1 << e.ch);
        chk("beat_last", c_last, {3'b0, e.last} << e.ch);
        chk("beat_data", c_data, e.data);
        chk("beat_last_valid", c_lv, e.lv);
      end
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(int ch, bit last);
    mem_gnt = 1;
    mem_last = last;
    mem_data = {8{32'hC0DE0000 + 32'(nbeat)}};
    mem_last_valid = last ? 5'd31 : 5'd0;
    nbeat++;
    if (ch >= 0) sb.push_back('{ch, last, mem_last_valid, mem_data});
    tick();
    mem_gnt = 0;
    mem_last = 0;
  endtask

  task automatic set_ch(int ch, logic [AW-1:0] addr, logic [AW-1:0] size);
    cl_start_addr[ch*AW +: AW] = addr;
    cl_size_bytes[ch*AW +: AW] = size;
  endtask

  task automatic do_reset();
    rst = 1;
    cl_req = '0;
    tick();
    rst = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    int order[5] = '{0, 1, 2, 3, 0};
    cl_req = '0; cl_start_addr = '0; cl_size_bytes = '0;
    mem_gnt = 0; mem_last = 0; mem_data = '0; mem_last_valid = '0;
    tick(); tick();
    chk("rst_mem_req", c_req, 0);
    chk("rst_busy", c_busy, 0);
    chk("rst_owner", c_owner, 0);
    chk("rst_cl_gnt", c_gnt, 0);
    chk("rst_addr", c_addr, 0);
    chk("rst_size", c_size, 0);
    rst = 0;
    // single channel, three beats
    set_ch(2, 19'h01000, 19'd96);
    cl_req = 4'b0100;
    chk("t1_req_not_yet", c_req, 0);
    tick();
    chk("t1_mem_req", c_req, 1);
    chk("t1_addr", c_addr, 19'h01000);
    chk("t1_size", c_size, 96);
    chk("t1_owner", c_owner, 2);
    beat(2, 0); beat(2, 0); beat(2, 1);
    cl_req = '0;
    chk("t1_req_drop", c_req, 0);
    chk("t1_owner_hold", c_owner, 2);
    // round-robin with all channels requesting
    do_reset();
    for (int i = 0; i < N; i++) set_ch(i, 19'(i * 'h100), 19'd32);
    cl_req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t2_owner", c_owner, order[k]);
      chk("t2_addr", c_addr, order[k] * 'h100);
      beat(order[k], 1);
      chk("t2_gap", c_req, 0);
    end
    cl_req = '0;
    // fixed priority
    sel = 1;
    do_reset();
    cl_req = 4'hF;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t3_owner_ch0", c_owner, 0);
      beat(0, 1);
      chk("t3_gap", c_req, 0);
    end
    cl_req = 4'hE;
    tick();
    chk("t3_owner_ch1", c_owner, 1);
    beat(1, 1);
    cl_req = '0;
    tick();
    // late requester waits for lock release
    sel = 0;
    do_reset();
    set_ch(1, 19'h02000, 19'd128);
    set_ch(3, 19'h03000, 19'd64);
    cl_req = 4'b0010;
    tick();
    chk("t4_owner_ch1", c_owner, 1);
    beat(1, 0);
    cl_req = 4'b1010;
    beat(1, 0);
    chk("t4_locked", c_owner, 1);
    beat(1, 0); beat(1, 1);
    cl_req = 4'b1000;
    chk("t4_gap", c_req, 0);
    mem_gnt = 1;
    #1 chk("t4_stray_gnt", c_gnt, 0);
    mem_gnt = 0;
    tick();
    chk("t4_owner_ch3", c_owner, 3);
    chk("t4_addr_ch3", c_addr, 19'h03000);
    mem_last = 1;
    #1 chk("t4_last_no_gnt", c_last, 0);
    mem_last = 0;
    tick();
    chk("t4_still_busy", c_req, 1);
    beat(3, 1);
    cl_req = '0;
    // reset mid-transaction clears pointer
    set_ch(2, 19'h04000, 19'd160);
    cl_req = 4'b0010;
    tick();
    chk("t5_owner_ch1", c_owner, 1);
    beat(1, 1);
    cl_req = 4'b0100;
    tick();
    chk("t5_owner_ch2", c_owner, 2);
    beat(2, 0);
    rst = 1;
    beat(2, 0);
    rst = 0;
    cl_req = 4'b1010;
    mem_gnt = 1;
    #1;
    chk("t5_rst_mem_req", c_req, 0);
    chk("t5_rst_busy", c_busy, 0);
    chk("t5_rst_owner", c_owner, 0);
    chk("t5_rst_gnt", c_gnt, 0);
    mem_gnt = 0;
    tick();
    chk("t5_rearb_owner", c_owner, 1);
    beat(1, 1);
    cl_req = '0;
    tick(); tick();
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_read_arb.md
Name: mem_read_arb

Overview:
- N-channel read arbiter that multiplexes NUM_CH client read channels onto one memory read port.
- Both sides use the mem_req/mem_gnt/last/mem_data/mem_last_valid read handshake.
- Grants are round-robin or fixed-priority (MODE), and ownership is locked from grant until the owner's final beat (last).
- Sits between the compute engines (activation/weight fetch) and the shared SRAM read controller.

Parameters:
- WORD_WIDTH, 8, bits per word.
- NUM_WORDS_IN_LINE, 32, words per memory line; LINE_W = WORD_WIDTH*NUM_WORDS_IN_LINE.
- ADDR_WIDTH, 19, byte address width; size field is also ADDR_WIDTH.
- NUM_CH, 4, number of client channels (>=2); CH_W = $clog2(NUM_CH).
- MODE, 0, 0 = round-robin, 1 = fixed priority (channel 0 highest).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- cl_req  in  NUM_CH  per-channel read request.
- cl_start_addr  in  NUM_CH*ADDR_WIDTH  per-channel start byte address; channel i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- cl_size_bytes  in  NUM_CH*ADDR_WIDTH  per-channel transfer size in bytes.
- cl_gnt  out  NUM_CH  per-channel data-beat valid.
- cl_last  out  NUM_CH  per-channel final-beat flag.
- cl_data  out  LINE_W  read data, broadcast to all channels.
- cl_last_valid  out  $clog2(LINE_W/8)  valid byte count minus 1 on the final beat, broadcast.
- mem_req  out  1  request to memory.
- mem_start_addr  out  ADDR_WIDTH  latched start address of the owner.
- mem_size_bytes  out  ADDR_WIDTH  latched size of the owner.
- mem_gnt  in  1  memory data-beat valid.
- mem_last  in  1  memory final beat.
- mem_data  in  LINE_W  memory read data.
- mem_last_valid  in  $clog2(LINE_W/8)  memory final-beat valid byte count minus 1.
- busy  out  1  a transaction is in progress.
- owner  out  CH_W  index of the current owner; holds its last value when idle.

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - state=IDLE, owner=0, RR pointer=0.
  - mem_req=0, mem_start_addr=0, mem_size_bytes=0, busy=0.
  - cl_gnt=0, cl_last=0.
  - Reset mid-transaction aborts without completing; the memory side is reset by the same rst.
- Client rule: hold cl_req, cl_start_addr and cl_size_bytes stable until cl_last is seen; deassert cl_req no later than the cycle after cl_last.
- States:
  - IDLE: if any cl_req, pick a winner. Next edge: state=BUSY, owner=winner, and the winner's addr/size are latched into mem_start_addr/mem_size_bytes.
  - BUSY: mem_req=1 (decoded from state, no extra register). On mem_gnt & mem_last: state=IDLE next edge; RR pointer=(owner+1) mod NUM_CH if MODE=0.
- Latency:
  - Client req to mem_req: 1 cycle.
  - mem_req drops in the cycle after the final beat.
  - Minimum gap between consecutive transactions is 1 IDLE cycle.
- Winner selection:
  - MODE=0: lowest-index requester at or after the RR pointer, wrapping from NUM_CH-1 to 0.
  - MODE=1: lowest-index requester.
- Return path (combinational, 0 latency):
  - cl_gnt[owner]=mem_gnt and cl_last[owner]=mem_gnt&mem_last while BUSY; all other bits 0.
  - cl_data=mem_data and cl_last_valid=mem_last_valid always.
- mem_last without mem_gnt is ignored.
- mem_gnt while IDLE is ignored; cl_gnt stays 0.
- Owner drops cl_req mid-transaction: the transaction continues to mem_last and beats are still forwarded. No abort.
- New requests during BUSY wait; they are not queued beyond their held cl_req.
- Single-beat transaction (mem_gnt & mem_last in the first BUSY cycle) is legal.
- Sizes are passed unchecked; size 0 is forwarded as is.

Decomposition:
- Package mannix_mem_pkg:
  - LINE_W and LAST_VALID_W localparam functions of WORD_WIDTH/NUM_WORDS_IN_LINE.
  - State enum typedef arb_state_t {IDLE, BUSY}.
  - MODE constants ARB_RR=0, ARB_FIXED=1.
- Sub-module rr_pick: combinational rotating-priority picker.
  - Inputs: req vector, pointer, mode.
  - Outputs: valid, index.
  - Implemented as double-width mask-and-find-first.

Test Plan:
- Single channel, MODE=0: ch2 req, addr 0x01000, size 96. Expect mem_req 1 cycle later with addr 0x01000 and size 96. Memory gives 3 gnt beats, last on the 3rd with last_valid=31. Expect cl_gnt[2] x3, cl_last[2] on beat 3, mem_req=0 the next cycle, owner=2.
- All four channels requesting continuously, MODE=0, each 1 beat: grant order 0,1,2,3,0. Exactly 1 IDLE cycle between each.
- Same stimulus with MODE=1: ch0 wins every transaction while it keeps requesting; ch1 is served only after ch0 drops its req.
- ch1 owns a 4-beat transaction; ch3 asserts req at beat 2. Expect ch3 not granted until after ch1's last. Stray mem_gnt while IDLE produces cl_gnt=0.
- rst=1 at beat 2 of a 5-beat transaction: next cycle mem_req=0, busy=0, owner=0, cl_gnt=0. Re-arbitration starts from pointer 0.
